// File: rtl/frame_rect_writer_pkg.sv
// Shared frame-buffer constants and types for the rectangle writer.
// Frame geometry, pixel/address widths, FSM states, command bundle, clip helper.
package frame_rect_writer_pkg;

  localparam int FB_H_RES = 400;
  localparam int FB_V_RES = 300;
  localparam int ADDR_W   = 19;
  localparam int PIX_W    = 4;
  localparam int COORD_W  = 10;

  typedef enum logic [1:0] {
    IDLE,
    CLIP,
    FILL,
    DONE
  } frw_state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
    logic [PIX_W-1:0]   color;
  } rect_cmd_t;

  // Exclusive end coordinate, saturated at the frame edge.
  // One extra bit keeps start+len from wrapping.
  function automatic logic [COORD_W:0] clip_end(
    input logic [COORD_W-1:0] start,
    input logic [COORD_W-1:0] len,
    input int                 lim
  );
    logic [COORD_W:0] sum;
    sum = {1'b0, start} + {1'b0, len};
    if (int'(sum) > lim) begin
      return (COORD_W+1)'(lim);
    end
    return sum;
  endfunction

endpackage

// File: rtl/frame_rect_writer_fb_addr_gen.sv
// Row-major pixel walker: column/row counters plus running row base.
// Ports: clk, rst_n, load_i, step_i, stall_i, x_i/y_i start, x_end_i/y_end_i, addr_o, last_o.
module fb_addr_gen
  import frame_rect_writer_pkg::*;
#(
  parameter int H_RES = FB_H_RES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               stall_i,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic [COORD_W:0]   x_end_i,
  input  logic [COORD_W:0]   y_end_i,
  output logic [ADDR_W-1:0]  addr_o,
  output logic               last_o
);

  localparam logic [COORD_W:0] ONE_W = 1;

  logic [COORD_W-1:0] col_q, col_d;
  logic [COORD_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic               col_last;
  logic               row_last;

  assign col_last = ({1'b0, col_q} + ONE_W) == x_end_i;
  assign row_last = ({1'b0, row_q} + ONE_W) == y_end_i;
  assign last_o   = col_last && row_last;
  assign addr_o   = base_q + ADDR_W'(col_q);

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    base_d = base_q;
    if (load_i) begin
      col_d  = x_i;
      row_d  = y_i;
      // Constant multiplicand: reduces to a fixed shift-add once per load.
      base_d = ADDR_W'(int'(y_i) * H_RES);
    end else if (step_i && !stall_i) begin
      if (col_last) begin
        col_d  = x_i;
        row_d  = row_q + COORD_W'(1);
        base_d = base_q + ADDR_W'(H_RES);
      end else begin
        col_d  = col_q + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      base_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      base_q <= base_d;
    end
  end

endmodule

// File: rtl/frame_rect_writer.sv
// Fills a clipped rectangle of the frame buffer with one colour, one pixel per cycle.
// Ports: pclk/rst_n, cmd_* handshake+fields, vblnk_in gate, wr_* memory port, busy/done.
module frame_rect_writer
  import frame_rect_writer_pkg::*;
#(
  parameter int H_RES       = FB_H_RES,
  parameter int V_RES       = FB_V_RES,
  parameter int GATE_VBLANK = 1
) (
  input  logic               pclk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_x,
  input  logic [COORD_W-1:0] cmd_y,
  input  logic [COORD_W-1:0] cmd_w,
  input  logic [COORD_W-1:0] cmd_h,
  input  logic [PIX_W-1:0]   cmd_color,
  input  logic               vblnk_in,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [PIX_W-1:0]   wr_data,
  output logic               busy,
  output logic               done
);

  frw_state_e        state_q, state_d;
  rect_cmd_t         cmd_q, cmd_d;
  logic [COORD_W:0]  x_end_q, x_end_d;
  logic [COORD_W:0]  y_end_q, y_end_d;
  // Held low through reset so cmd_ready stays 0 until the first live edge.
  logic              live_q;
  logic              fill_en;
  logic              empty;
  logic              ag_load;
  logic              ag_step;
  logic              ag_last;
  logic [ADDR_W-1:0] ag_addr;

  assign fill_en = (GATE_VBLANK == 0) || vblnk_in;

  assign empty = (cmd_q.w == '0)
              || (cmd_q.h == '0)
              || (int'(cmd_q.x) >= H_RES)
              || (int'(cmd_q.y) >= V_RES);

  fb_addr_gen #(
    .H_RES (H_RES)
  ) u_addr_gen (
    .clk     (pclk),
    .rst_n   (rst_n),
    .load_i  (ag_load),
    .step_i  (ag_step),
    .stall_i (!fill_en),
    .x_i     (cmd_q.x),
    .y_i     (cmd_q.y),
    .x_end_i (x_end_q),
    .y_end_i (y_end_q),
    .addr_o  (ag_addr),
    .last_o  (ag_last)
  );

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    x_end_d   = x_end_q;
    y_end_d   = y_end_q;
    ag_load   = 1'b0;
    ag_step   = 1'b0;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    unique case (state_q)
      IDLE: begin
        busy      = 1'b0;
        cmd_ready = live_q;
        if (cmd_valid && live_q) begin
          cmd_d.x     = cmd_x;
          cmd_d.y     = cmd_y;
          cmd_d.w     = cmd_w;
          cmd_d.h     = cmd_h;
          cmd_d.color = cmd_color;
          state_d     = CLIP;
        end
      end
      CLIP: begin
        x_end_d = clip_end(cmd_q.x, cmd_q.w, H_RES);
        y_end_d = clip_end(cmd_q.y, cmd_q.h, V_RES);
        ag_load = 1'b1;
        state_d = empty ? DONE : FILL;
      end
      FILL: begin
        ag_step = 1'b1;
        if (fill_en) begin
          wr_en   = 1'b1;
          wr_addr = ag_addr;
          wr_data = cmd_q.color;
          if (ag_last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      x_end_q <= '0;
      y_end_q <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      x_end_q <= x_end_d;
      y_end_q <= y_end_d;
      live_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_rect_writer.sv
// Self-checking bench for frame_rect_writer: ungated and vblank-gated instances.
// Randomised rectangles checked against a row-major pixel list model.
module tb_frame_rect_writer;

  localparam int H = 400;
  localparam int V = 300;

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  logic       pclk  = 1'b0;
  logic       rst_n = 1'b0;
  logic       v0    = 1'b0;
  logic       v1    = 1'b0;
  logic       vblnk = 1'b1;
  logic [9:0] cx    = '0;
  logic [9:0] cy    = '0;
  logic [9:0] cw    = '0;
  logic [9:0] ch    = '0;
  logic [3:0] cc    = '0;

  logic        rdy0, wen0, busy0, done0;
  logic [18:0] addr0;
  logic [3:0]  data0;
  logic        rdy1, wen1, busy1, done1;
  logic [18:0] addr1;
  logic [3:0]  data1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  wr_t wq0[$];
  wr_t wq1[$];
  int  dq0[$];
  int  dq1[$];
  int  exp_a[$];
  int  exp_d[$];
  wr_t got[$];
  int  gotd[$];
  wr_t m0;
  wr_t m1;

  frame_rect_writer #(
    .H_RES(400), .V_RES(300), .GATE_VBLANK(0)
  ) u_ug (
    .pclk(pclk), .rst_n(rst_n),
    .cmd_valid(v0), .cmd_ready(rdy0),
    .cmd_x(cx), .cmd_y(cy), .cmd_w(cw), .cmd_h(ch),
    .cmd_color(cc), .vblnk_in(vblnk),
    .wr_en(wen0), .wr_addr(addr0), .wr_data(data0),
    .busy(busy0), .done(done0)
  );

  frame_rect_writer #(
    .H_RES(400), .V_RES(300), .GATE_VBLANK(1)
  ) u_g (
    .pclk(pclk), .rst_n(rst_n),
    .cmd_valid(v1), .cmd_ready(rdy1),
    .cmd_x(cx), .cmd_y(cy), .cmd_w(cw), .cmd_h(ch),
    .cmd_color(cc), .vblnk_in(vblnk),
    .wr_en(wen1), .wr_addr(addr1), .wr_data(data1),
    .busy(busy1), .done(done1)
  );

  initial forever #5 pclk = ~pclk;

  initial forever begin
    @(posedge pclk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time expired, got running want finished");
    $fatal(1);
  end

  initial forever begin
    @(negedge pclk);
    n_checks++;
    if (!wen0 && (addr0 !== '0 || data0 !== '0)) begin
      n_fail++;
      $display("FAIL idle_bus0: got %0d/%0d want 0/0", addr0, data0);
    end
    if (wen0) begin
      n_checks++;
      if (int'(addr0) >= H * V) begin
        n_fail++;
        $display("FAIL addr_range0: got %0d want < %0d", addr0, H * V);
      end
      m0.cyc = cyc;
      m0.addr = int'(addr0);
      m0.data = int'(data0);
      wq0.push_back(m0);
    end
    if (done0) dq0.push_back(cyc);
  end

  initial forever begin
    @(negedge pclk);
    n_checks++;
    if (!wen1 && (addr1 !== '0 || data1 !== '0)) begin
      n_fail++;
      $display("FAIL idle_bus1: got %0d/%0d want 0/0", addr1, data1);
    end
    if (wen1) begin
      n_checks++;
      if (int'(addr1) >= H * V || !vblnk) begin
        n_fail++;
        $display("FAIL gated_wr1: got addr %0d vblnk %0b want <%0d, 1",
                 addr1, vblnk, H * V);
      end
      m1.cyc = cyc;
      m1.addr = int'(addr1);
      m1.data = int'(data1);
      wq1.push_back(m1);
    end
    if (done1) dq1.push_back(cyc);
  end

  task automatic clear_all();
    wq0.delete(); wq1.delete();
    dq0.delete(); dq1.delete();
    exp_a.delete(); exp_d.delete();
  endtask

  // Expected pixels: every in-frame (x,y) of the rectangle, row-major.
  task automatic model_rect(input int x, input int y, input int w,
                            input int h, input int c);
    for (int yy = y; yy < y + h; yy++) begin
      for (int xx = x; xx < x + w; xx++) begin
        if (xx < H && yy < V) begin
          exp_a.push_back(yy * H + xx);
          exp_d.push_back(c);
        end
      end
    end
  endtask

  task automatic send_cmd(input int d, input int x, input int y,
                          input int w, input int h, input int c,
                          output int acc, output bit ok);
    logic r;
    @(posedge pclk); #1;
    cx = 10'(x); cy = 10'(y); cw = 10'(w); ch = 10'(h); cc = 4'(c);
    if (d == 0) v0 = 1'b1; else v1 = 1'b1;
    acc = -1;
    for (int k = 0; k < 50 && acc < 0; k++) begin
      @(negedge pclk);
      r = (d == 0) ? rdy0 : rdy1;
      if (r) acc = cyc;
    end
    @(posedge pclk); #1;
    v0 = 1'b0; v1 = 1'b0;
    ok = (acc >= 0);
  endtask

  task automatic wait_done(input int d, input int n, input int budget,
                           input bit rnd_v, output bit ok);
    int sz;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge pclk); #1;
      if (rnd_v) vblnk = ($urandom_range(0, 9) < 7);
      @(negedge pclk); #1;
      sz = (d == 0) ? dq0.size() : dq1.size();
      if (sz >= n) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge pclk); #1;
    vblnk = 1'b1;
    @(negedge pclk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; vblnk = 1'b1;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    n_checks++;
    if ({wen0, addr0, data0, busy0, done0, rdy0} !== '0 ||
        {wen1, addr1, data1, busy1, done1, rdy1} !== '0) begin
      n_fail++;
      $display("FAIL reset_out: got %b %h %h %b %b %b want all 0",
               wen0, addr0, data0, busy0, done0, rdy0);
    end
    @(posedge pclk); #1;
    rst_n = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    n_checks++;
    if (rdy0 !== 1'b1 || busy0 !== 1'b0 || rdy1 !== 1'b1 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got rdy %b%b busy %b%b want 11 00",
               rdy0, rdy1, busy0, busy1);
    end
  endtask

  task automatic test_basic();
    int acc;
    bit ok;
    bit ok2;
    int last;
    clear_all();
    vblnk = 1'b0;
    model_rect(10, 2, 3, 2, 5);
    send_cmd(0, 10, 2, 3, 2, 5, acc, ok);
    wait_done(0, 1, 40, 1'b0, ok2);
    repeat (2) @(negedge pclk);
    #1;
    got = wq0; gotd = dq0;
    n_checks++;
    if (!ok || !ok2 || got.size() != 6) begin
      n_fail++;
      $display("FAIL basic_count: got %0d writes (ok %b%b) want 6", got.size(), ok, ok2);
    end
    for (int i = 0; i < got.size() && i < exp_a.size(); i++) begin
      n_checks++;
      if (got[i].addr != exp_a[i] || got[i].data != exp_d[i]) begin
        n_fail++;
        $display("FAIL basic_px[%0d]: got %0d/%0d want %0d/%0d",
                 i, got[i].addr, got[i].data, exp_a[i], exp_d[i]);
      end
    end
    n_checks++;
    if (got.size() == 0 || got[0].cyc != acc + 2) begin
      n_fail++;
      $display("FAIL basic_latency: got first at %0d want %0d",
               got.size() ? got[0].cyc : -1, acc + 2);
    end
    n_checks++;
    if (got.size() == 6 && got[5].cyc != got[0].cyc + 5) begin
      n_fail++;
      $display("FAIL basic_burst: got last at %0d want %0d", got[5].cyc, got[0].cyc + 5);
    end
    last = got.size() ? got[got.size()-1].cyc : -10;
    n_checks++;
    if (gotd.size() != 1 || gotd[0] != last + 1) begin
      n_fail++;
      $display("FAIL basic_done: got %0d pulses at %0d want 1 at %0d",
               gotd.size(), gotd.size() ? gotd[0] : -1, last + 1);
    end
  endtask

  task automatic test_clip();
    int acc;
    bit ok;
    bit ok2;
    clear_all();
    model_rect(398, 299, 5, 5, 7);
    send_cmd(0, 398, 299, 5, 5, 7, acc, ok);
    wait_done(0, 1, 40, 1'b0, ok2);
    got = wq0; gotd = dq0;
    n_checks++;
    if (!ok || !ok2 || got.size() != 2 || exp_a.size() != 2) begin
      n_fail++;
      $display("FAIL clip_count: got %0d writes want 2", got.size());
    end
    for (int i = 0; i < got.size() && i < exp_a.size(); i++) begin
      n_checks++;
      if (got[i].addr != exp_a[i] || got[i].data != 7) begin
        n_fail++;
        $display("FAIL clip_px[%0d]: got %0d/%0d want %0d/7",
                 i, got[i].addr, got[i].data, exp_a[i]);
      end
    end
    n_checks++;
    if (gotd.size() != 1 || got.size() == 0 || gotd[0] != got[got.size()-1].cyc + 1) begin
      n_fail++;
      $display("FAIL clip_done: got %0d pulses want 1 after last write", gotd.size());
    end
  endtask

  task automatic test_degenerate();
    int acc;
    bit ok;
    bit ok2;
    int cases[2][4];
    cases[0] = '{5, 5, 0, 3};
    cases[1] = '{400, 0, 2, 2};
    for (int t = 0; t < 2; t++) begin
      clear_all();
      send_cmd(0, cases[t][0], cases[t][1], cases[t][2], cases[t][3], 4, acc, ok);
      wait_done(0, 1, 20, 1'b0, ok2);
      n_checks++;
      if (!ok || !ok2 || wq0.size() != 0) begin
        n_fail++;
        $display("FAIL degen%0d_writes: got %0d want 0", t, wq0.size());
      end
      n_checks++;
      if (dq0.size() != 1 || dq0[0] != acc + 2) begin
        n_fail++;
        $display("FAIL degen%0d_done: got %0d pulses at %0d want 1 at %0d",
                 t, dq0.size(), dq0.size() ? dq0[0] : -1, acc + 2);
      end
    end
  endtask

  task automatic test_gating();
    int acc;
    bit ok;
    bit ok2;
    int bad;
    clear_all();
    vblnk = 1'b1;
    model_rect(20, 10, 4, 3, 3);
    send_cmd(1, 20, 10, 4, 3, 3, acc, ok);
    for (int k = 0; k < 40; k++) begin
      @(negedge pclk); #1;
      if (wq1.size() >= 4) break;
    end
    @(posedge pclk); #1;
    vblnk = 1'b0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge pclk);
      if (wen1) bad++;
      @(posedge pclk); #1;
    end
    vblnk = 1'b1;
    wait_done(1, 1, 40, 1'b0, ok2);
    got = wq1;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL gate_hold: got %0d writes in blank gap want 0", bad);
    end
    n_checks++;
    if (!ok || !ok2 || got.size() != exp_a.size()) begin
      n_fail++;
      $display("FAIL gate_count: got %0d want %0d", got.size(), exp_a.size());
    end
    for (int i = 0; i < got.size() && i < exp_a.size(); i++) begin
      n_checks++;
      if (got[i].addr != exp_a[i] || got[i].data != exp_d[i]) begin
        n_fail++;
        $display("FAIL gate_px[%0d]: got %0d want %0d", i, got[i].addr, exp_a[i]);
      end
    end
    n_checks++;
    if (got.size() < 5 || got[4].cyc != got[3].cyc + 6) begin
      n_fail++;
      $display("FAIL gate_resume: got gap %0d want 6",
               got.size() >= 5 ? got[4].cyc - got[3].cyc : -1);
    end
  endtask

  task automatic test_back_to_back();
    int accs[$];
    bit ok;
    clear_all();
    for (int k = 0; k < 25; k++) begin
      @(posedge pclk); #1;
      cx = 10'(50 + k); cy = 10'd5; cw = 10'd2; ch = 10'd1; cc = 4'(k);
      v0 = 1'b1;
      @(negedge pclk);
      if (rdy0) begin
        n_checks++;
        if (busy0) begin
          n_fail++;
          $display("FAIL b2b_ready_busy: got busy 1 want 0 with ready");
        end
        accs.push_back(cyc);
        model_rect(50 + k, 5, 2, 1, k % 16);
      end
    end
    @(posedge pclk); #1;
    v0 = 1'b0;
    wait_done(0, accs.size(), 40, 1'b0, ok);
    got = wq0;
    n_checks++;
    if (!ok || accs.size() < 2 || dq0.size() != accs.size()) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d accepts %0d dones want >=2 equal",
               accs.size(), dq0.size());
    end
    for (int i = 1; i < accs.size(); i++) begin
      n_checks++;
      if (accs[i] - accs[i-1] != 5) begin
        n_fail++;
        $display("FAIL b2b_spacing[%0d]: got %0d want 5", i, accs[i] - accs[i-1]);
      end
    end
    n_checks++;
    if (got.size() != exp_a.size()) begin
      n_fail++;
      $display("FAIL b2b_writes: got %0d want %0d", got.size(), exp_a.size());
    end
    for (int i = 0; i < got.size() && i < exp_a.size(); i++) begin
      n_checks++;
      if (got[i].addr != exp_a[i] || got[i].data != exp_d[i]) begin
        n_fail++;
        $display("FAIL b2b_px[%0d]: got %0d/%0d want %0d/%0d",
                 i, got[i].addr, got[i].data, exp_a[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_random();
    int acc;
    bit ok;
    bit ok2;
    int x, y, w, h, c;
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 10; n++) begin
        clear_all();
        x = ($urandom_range(0, 3) == 0) ? $urandom_range(390, 405) : $urandom_range(0, 399);
        y = ($urandom_range(0, 3) == 0) ? $urandom_range(290, 305) : $urandom_range(0, 299);
        w = $urandom_range(0, 12);
        h = $urandom_range(0, 6);
        c = $urandom_range(0, 15);
        model_rect(x, y, w, h, c);
        send_cmd(d, x, y, w, h, c, acc, ok);
        wait_done(d, 1, 400, 1'b1, ok2);
        if (d == 0) begin got = wq0; gotd = dq0; end
        else begin got = wq1; gotd = dq1; end
        n_checks++;
        if (!ok || !ok2 || got.size() != exp_a.size() || gotd.size() != 1) begin
          n_fail++;
          $display("FAIL rand%0d_%0d (%0d,%0d,%0d,%0d): got %0d writes %0d dones want %0d 1",
                   d, n, x, y, w, h, got.size(), gotd.size(), exp_a.size());
        end
        for (int i = 0; i < got.size() && i < exp_a.size(); i++) begin
          n_checks++;
          if (got[i].addr != exp_a[i] || got[i].data != exp_d[i]) begin
            n_fail++;
            $display("FAIL rand%0d_%0d_px[%0d]: got %0d/%0d want %0d/%0d",
                     d, n, i, got[i].addr, got[i].data, exp_a[i], exp_d[i]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    bit ok;
    bit ok2;
    clear_all();
    send_cmd(0, 100, 100, 4, 4, 6, acc, ok);
    for (int k = 0; k < 40; k++) begin
      @(negedge pclk); #1;
      if (wq0.size() >= 3) break;
    end
    rst_n = 1'b0;
    @(negedge pclk); #1;
    n_checks++;
    if ({wen0, addr0, data0, busy0, done0, rdy0} !== '0 || wq0.size() != 3) begin
      n_fail++;
      $display("FAIL rstmid_out: got %b %h %h %b %b %b writes %0d want all 0, 3",
               wen0, addr0, data0, busy0, done0, rdy0, wq0.size());
    end
    @(posedge pclk); #1;
    rst_n = 1'b1;
    repeat (4) @(negedge pclk);
    #1;
    n_checks++;
    if (!ok || dq0.size() != 0 || wq0.size() != 3) begin
      n_fail++;
      $display("FAIL rstmid_abort: got %0d dones %0d writes want 0 3",
               dq0.size(), wq0.size());
    end
    clear_all();
    send_cmd(0, 7, 8, 1, 1, 9, acc, ok);
    wait_done(0, 1, 20, 1'b0, ok2);
    n_checks++;
    if (!ok || !ok2 || wq0.size() != 1 || dq0.size() != 1) begin
      n_fail++;
      $display("FAIL rstmid_next_count: got %0d writes %0d dones want 1 1",
               wq0.size(), dq0.size());
    end
    n_checks++;
    if (wq0.size() == 0 || wq0[0].addr != 8 * H + 7 || wq0[0].data != 9) begin
      n_fail++;
      $display("FAIL rstmid_next_px: got %0d/%0d want %0d/9",
               wq0.size() ? wq0[0].addr : -1, wq0.size() ? wq0[0].data : -1, 8 * H + 7);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clip();
    test_degenerate();
    test_gating();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_rect_writer.md
FRAME_RECT_WRITER -- requirements
Module: frame_rect_writer

Interface
REQ-001 SHALL have parameter H_RES, default 400, frame width in pixels.
REQ-002 SHALL have parameter V_RES, default 300, frame height in pixels.
REQ-003 SHALL have parameter GATE_VBLANK, default 1; when 1, writes occur only during vertical blank.
REQ-004 SHALL have port pclk, input, 1, the single clock; all logic rising-edge.
REQ-005 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have ports cmd_valid (input, 1) and cmd_ready (output, 1), the command handshake.
REQ-007 SHALL have ports cmd_x and cmd_y, input, 10 each, rectangle top-left corner.
REQ-008 SHALL have ports cmd_w and cmd_h, input, 10 each, rectangle size.
REQ-009 SHALL have port cmd_color, input, 4, fill value.
REQ-010 SHALL have port vblnk_in, input, 1, vertical blank from the VGA timing bus on pclk.
REQ-011 SHALL have ports wr_en (output, 1), wr_addr (output, 19) and wr_data (output, 4), the frame memory write port.
REQ-012 SHALL have ports busy (output, 1) and done (output, 1, one-cycle pulse).

Function
REQ-013 SHALL address the memory as wr_addr = y*H_RES + x, the same row-major 4-bit-per-pixel layout the display reader uses.
REQ-014 SHALL use FSM states IDLE, CLIP, FILL, DONE.
REQ-015 SHALL, in IDLE, drive cmd_ready=1 and busy=0, and capture all cmd_* fields on cmd_valid&&cmd_ready, then go to CLIP.
REQ-016 SHALL, in CLIP (one cycle), clip to the frame: x_end=min(x+w,H_RES), y_end=min(y+h,V_RES), using 11-bit sums with no wrap.
REQ-017 SHALL go from CLIP to DONE with zero writes if w==0, h==0, x>=H_RES or y>=V_RES; otherwise go to FILL.
REQ-018 SHALL compute the address in FILL incrementally: row_base += H_RES per row and column counter +1, with no multiplier in the datapath.
REQ-019 SHALL, in FILL, write one pixel per enabled cycle in row-major order, from (x,y) to (x_end-1,y_end-1).
REQ-020 SHALL, with GATE_VBLANK=1 and vblnk_in=0, deassert wr_en and hold the counters; the fill resumes at the same pixel when vblnk_in returns.
REQ-021 SHALL ignore vblnk_in when GATE_VBLANK=0.
REQ-022 SHALL hold the first wr_en high in the cycle after CLIP when ungated, giving 2 cycles of latency from accept to first write.
REQ-023 SHALL move to DONE the cycle after the last write, pulse done=1 for exactly one cycle, then return to IDLE.
REQ-024 SHALL drive cmd_ready=0 and busy=1 in CLIP, FILL and DONE; cmd_valid there is ignored and not queued.
REQ-025 SHALL keep wr_data equal to the captured colour while in FILL.
REQ-026 SHALL drive wr_addr and wr_data to 0 whenever wr_en=0.
REQ-027 SHALL keep wr_addr below H_RES*V_RES in every write cycle.

Reset
REQ-028 SHALL, with rst_n=0 at a pclk edge, enter IDLE and set wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0 and cmd_ready=0.
REQ-029 SHALL assert cmd_ready=1 from the first cycle after rst_n is released.
REQ-030 SHALL, on reset mid-FILL, abort with no further writes and no done pulse; the next command executes fully.

Structure
REQ-031 SHALL take H_RES, V_RES, ADDR_W=19 and PIX_W=4 from the shared frame-buffer constants package, also used by the display reader.
REQ-032 SHALL place the column/row counters and running row_base in one sub-module, fb_addr_gen, with ports for load, step and stall.
REQ-033 SHALL be a single clock domain with no memory instance; the memory's write port is driven externally.

Verification
REQ-034 SHALL cover a basic fill, GATE_VBLANK=0: cmd (10,2,3,2,color 5) -> 6 writes at addrs 810,811,812,1210,1211,1212 with data 5, first wr_en 2 cycles after accept, then a done pulse.
REQ-035 SHALL cover clipping: cmd (398,299,5,5,color 7) -> exactly 2 writes at addrs 119998 and 119999, then done.
REQ-036 SHALL cover degenerate commands: cmd w=0, and separately x=400 -> zero writes, done 2 cycles after accept.
REQ-037 SHALL cover gating, GATE_VBLANK=1: drop vblnk_in for 5 cycles mid-fill -> no wr_en in those 5 cycles, no pixel skipped or duplicated, total write count unchanged.
REQ-038 SHALL cover back-pressure: hold cmd_valid while busy with a changing cmd_x -> only the first command is executed; the second is accepted only in IDLE.
REQ-039 SHALL cover reset mid-operation: rst_n=0 after 3 writes of a 4x4 fill -> all outputs 0 next cycle, no done pulse; the following 1x1 command gives one correct write.
